// File: rtl/sccb_responder.sv
// SCCB target with a 256x8 register file: decodes 3-phase writes and
// 2-phase write + 2-phase read cycles, drives SIO_D open-drain.
module sccb_responder #(
   parameter logic [7:0] DEV_ID      = 8'h42,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sio_c_i,
   input  logic       sio_d_i,
   output logic       sio_d_oe,
   output logic       reg_wr_stb,
   output logic [7:0] reg_addr_o,
   output logic [7:0] reg_wdata_o,
   input  logic [7:0] reg_rd_addr_i,
   output logic [7:0] reg_rd_data_o,
   output logic       busy_o
);

   typedef enum logic [3:0] {
      IDLE, ID, ID_ACK, SUB, SUB_ACK,
      WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE
   } state_t;

   localparam logic [7:0] RD_ID = DEV_ID | 8'h01;

   logic [SYNC_STAGES-1:0] c_sync, d_sync;
   logic                   scl, sda, scl_q, sda_q;
   logic                   rise, fall, start_det, stop_det;

   state_t     state, state_d;
   logic [2:0] bit_cnt, bit_cnt_d;
   logic [6:0] sh, sh_d;
   logic [7:0] sub_ptr, sub_ptr_d;
   logic       rd_mode, rd_mode_d;
   logic       ack_ph, ack_ph_d;
   logic       oe_d, wr_en;
   logic [7:0] rx_byte, rd_byte;
   logic [7:0] regs [256];

   assign scl = c_sync[SYNC_STAGES-1];
   assign sda = d_sync[SYNC_STAGES-1];

   // Lines idle high, so the sync chain resets high to avoid a false edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         c_sync <= '1;
         d_sync <= '1;
         scl_q  <= 1'b1;
         sda_q  <= 1'b1;
      end else begin
         c_sync <= {c_sync[SYNC_STAGES-2:0], sio_c_i};
         d_sync <= {d_sync[SYNC_STAGES-2:0], sio_d_i};
         scl_q  <= scl;
         sda_q  <= sda;
      end
   end

   assign rise      = scl & ~scl_q;
   assign fall      = ~scl & scl_q;
   assign start_det = scl & scl_q & sda_q & ~sda;
   assign stop_det  = scl & scl_q & ~sda_q & sda;
   assign rx_byte   = {sh, sda};
   assign rd_byte   = regs[sub_ptr];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         sh       <= '0;
         sub_ptr  <= '0;
         rd_mode  <= 1'b0;
         ack_ph   <= 1'b0;
         sio_d_oe <= 1'b0;
      end else begin
         state    <= state_d;
         bit_cnt  <= bit_cnt_d;
         sh       <= sh_d;
         sub_ptr  <= sub_ptr_d;
         rd_mode  <= rd_mode_d;
         ack_ph   <= ack_ph_d;
         sio_d_oe <= oe_d;
      end
   end

   always_comb begin
      state_d   = state;
      bit_cnt_d = bit_cnt;
      sh_d      = sh;
      sub_ptr_d = sub_ptr;
      rd_mode_d = rd_mode;
      ack_ph_d  = ack_ph;
      oe_d      = sio_d_oe;
      wr_en     = 1'b0;
      if (stop_det) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         ack_ph_d  = 1'b0;
         oe_d      = 1'b0;
      end else if (start_det) begin
         state_d   = ID;
         bit_cnt_d = '0;
         ack_ph_d  = 1'b0;
         oe_d      = 1'b0;
      end else begin
         unique case (state)
            IDLE: ;
            ID, SUB, WDATA: begin
               if (rise) begin
                  sh_d      = rx_byte[6:0];
                  bit_cnt_d = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (state == ID) begin
                        if (rx_byte == DEV_ID) begin
                           state_d   = ID_ACK;
                           rd_mode_d = 1'b0;
                        end else if (rx_byte == RD_ID) begin
                           state_d   = ID_ACK;
                           rd_mode_d = 1'b1;
                        end else begin
                           state_d = IGNORE;
                        end
                     end else if (state == SUB) begin
                        sub_ptr_d = rx_byte;
                        state_d   = SUB_ACK;
                     end else begin
                        wr_en   = 1'b1;
                        state_d = WDATA_ACK;
                     end
                  end
               end
            end
            // First fall pulls SIO_D low, second fall releases and advances.
            ID_ACK, SUB_ACK, WDATA_ACK: begin
               if (fall) begin
                  ack_ph_d = ~ack_ph;
                  oe_d     = ~ack_ph;
                  if (ack_ph) begin
                     bit_cnt_d = '0;
                     if (state == SUB_ACK) begin
                        state_d = WDATA;
                     end else if (state == WDATA_ACK) begin
                        state_d = IGNORE;
                     end else if (!rd_mode) begin
                        state_d = SUB;
                     end else begin
                        state_d = RDATA;
                        sh_d    = rd_byte[6:0];
                        oe_d    = ~rd_byte[7];
                     end
                  end
               end
            end
            RDATA: begin
               if (rise) begin
                  bit_cnt_d = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state_d = RDATA_NA;
               end else if (fall) begin
                  sh_d = {sh[5:0], 1'b0};
                  oe_d = ~sh[6];
               end
            end
            RDATA_NA: begin
               if (fall) oe_d = 1'b0;
               if (rise) state_d = IGNORE;
            end
            IGNORE: oe_d = 1'b0;
            default: begin
               state_d = IDLE;
               oe_d    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < 256; i++) regs[i] <= '0;
         reg_wr_stb    <= 1'b0;
         reg_addr_o    <= '0;
         reg_wdata_o   <= '0;
         reg_rd_data_o <= '0;
         busy_o        <= 1'b0;
      end else begin
         reg_wr_stb    <= wr_en;
         reg_rd_data_o <= regs[reg_rd_addr_i];
         if (wr_en) begin
            regs[sub_ptr] <= rx_byte;
            reg_addr_o    <= sub_ptr;
            reg_wdata_o   <= rx_byte;
         end
         if (start_det) busy_o <= 1'b1;
         else if (stop_det) busy_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: a bit-banged SCCB master with an
// open-drain SIO_D model and hand-computed expected values.
module tb_sccb_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sio_c = 1'b1;
   logic       m_sda = 1'b1;
   logic       sio_d;
   logic       sio_d_oe, reg_wr_stb, busy_o;
   logic [7:0] reg_addr_o, reg_wdata_o, reg_rd_data_o;
   logic [7:0] reg_rd_addr_i = 8'h00;

   int checks = 0;
   int passes = 0;
   int oe_cnt = 0;
   int stb_cnt = 0;

   assign sio_d = m_sda & ~sio_d_oe;

   sccb_responder dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .sio_c_i      (sio_c),
      .sio_d_i      (sio_d),
      .sio_d_oe     (sio_d_oe),
      .reg_wr_stb   (reg_wr_stb),
      .reg_addr_o   (reg_addr_o),
      .reg_wdata_o  (reg_wdata_o),
      .reg_rd_addr_i(reg_rd_addr_i),
      .reg_rd_data_o(reg_rd_data_o),
      .busy_o       (busy_o)
   );

   always #10 clk = ~clk;

   always @(posedge clk) begin
      if (sio_d_oe) oe_cnt++;
      if (reg_wr_stb) stb_cnt++;
   end

   initial begin
      #4ms;
      $display("FAIL watchdog: run did not finish, required finish before 4ms");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_cycle(input logic d, output logic s);
      m_sda = d;
      tick(5);
      sio_c = 1'b1;
      tick(5);
      s = sio_d;
      tick(5);
      sio_c = 1'b0;
      tick(5);
   endtask

   task automatic do_start();
      m_sda = 1'b1;
      sio_c = 1'b1;
      tick(5);
      m_sda = 1'b0;
      tick(5);
      sio_c = 1'b0;
      tick(5);
   endtask

   task automatic do_stop();
      m_sda = 1'b0;
      tick(5);
      sio_c = 1'b1;
      tick(5);
      m_sda = 1'b1;
      tick(5);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
      bit_cycle(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(output logic [7:0] b, output logic na_oe);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_cycle(1'b1, s);
         b[i] = s;
      end
      m_sda = 1'b1;
      tick(5);
      sio_c = 1'b1;
      tick(5);
      na_oe = sio_d_oe;
      tick(5);
      sio_c = 1'b0;
      tick(5);
   endtask

   task automatic fab_read(input logic [7:0] a, output logic [7:0] d);
      reg_rd_addr_i = a;
      tick(2);
      d = reg_rd_data_o;
   endtask

   task automatic test_reset();
      tick(4);
      checks++;
      if (sio_d_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", sio_d_oe);
      else passes++;
      checks++;
      if (reg_wr_stb !== 1'b0) $display("FAIL reset_stb: got %b want 0", reg_wr_stb);
      else passes++;
      checks++;
      if (reg_addr_o !== 8'h00) $display("FAIL reset_addr: got %h want 00", reg_addr_o);
      else passes++;
      checks++;
      if (reg_wdata_o !== 8'h00) $display("FAIL reset_wdata: got %h want 00", reg_wdata_o);
      else passes++;
      checks++;
      if (reg_rd_data_o !== 8'h00) $display("FAIL reset_rdata: got %h want 00", reg_rd_data_o);
      else passes++;
      checks++;
      if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o);
      else passes++;
   endtask

   task automatic test_write3();
      logic a0, a1, a2;
      logic [7:0] d;
      int stb0;
      stb0 = stb_cnt;
      do_start();
      send_byte(8'h42, a0);
      checks++;
      if (busy_o !== 1'b1) $display("FAIL w3_busy: got %b want 1", busy_o);
      else passes++;
      send_byte(8'h12, a1);
      send_byte(8'h80, a2);
      do_stop();
      checks++;
      if ({a0, a1, a2} !== 3'b111) $display("FAIL w3_acks: got %b want 111", {a0, a1, a2});
      else passes++;
      checks++;
      if (stb_cnt - stb0 !== 1) $display("FAIL w3_stb: got %0d want 1", stb_cnt - stb0);
      else passes++;
      checks++;
      if (reg_addr_o !== 8'h12) $display("FAIL w3_addr: got %h want 12", reg_addr_o);
      else passes++;
      checks++;
      if (reg_wdata_o !== 8'h80) $display("FAIL w3_wdata: got %h want 80", reg_wdata_o);
      else passes++;
      checks++;
      if (busy_o !== 1'b0) $display("FAIL w3_busy_end: got %b want 0", busy_o);
      else passes++;
      fab_read(8'h12, d);
      checks++;
      if (d !== 8'h80) $display("FAIL w3_fabric: got %h want 80", d);
      else passes++;
   endtask

   task automatic test_read2();
      logic a0, a1, a2, na;
      logic [7:0] d;
      int stb0;
      stb0 = stb_cnt;
      do_start();
      send_byte(8'h42, a0);
      send_byte(8'h12, a1);
      do_stop();
      checks++;
      if (stb_cnt !== stb0) $display("FAIL r2_no_stb: got %0d want %0d", stb_cnt, stb0);
      else passes++;
      do_start();
      send_byte(8'h43, a2);
      read_byte(d, na);
      do_stop();
      checks++;
      if ({a0, a1, a2} !== 3'b111) $display("FAIL r2_acks: got %b want 111", {a0, a1, a2});
      else passes++;
      checks++;
      if (d !== 8'h80) $display("FAIL r2_data: got %h want 80", d);
      else passes++;
      checks++;
      if (na !== 1'b0) $display("FAIL r2_na_oe: got %b want 0", na);
      else passes++;
      checks++;
      if (sio_d_oe !== 1'b0) $display("FAIL r2_release: got %b want 0", sio_d_oe);
      else passes++;
   endtask

   task automatic test_bad_id();
      logic a0, a1;
      int oe0, stb0;
      oe0 = oe_cnt;
      stb0 = stb_cnt;
      do_start();
      send_byte(8'h60, a0);
      send_byte(8'h12, a1);
      checks++;
      if ({a0, a1} !== 2'b00) $display("FAIL bad_acks: got %b want 00", {a0, a1});
      else passes++;
      checks++;
      if (busy_o !== 1'b1) $display("FAIL bad_busy: got %b want 1", busy_o);
      else passes++;
      do_stop();
      checks++;
      if (oe_cnt !== oe0) $display("FAIL bad_oe: got %0d want %0d", oe_cnt, oe0);
      else passes++;
      checks++;
      if (stb_cnt !== stb0) $display("FAIL bad_stb: got %0d want %0d", stb_cnt, stb0);
      else passes++;
      checks++;
      if (busy_o !== 1'b0) $display("FAIL bad_busy_end: got %b want 0", busy_o);
      else passes++;
   endtask

   task automatic test_no_autoinc();
      logic a0, a1, a2, a3;
      logic [7:0] d;
      int stb0;
      stb0 = stb_cnt;
      do_start();
      send_byte(8'h42, a0);
      send_byte(8'h20, a1);
      send_byte(8'h11, a2);
      send_byte(8'h22, a3);
      do_stop();
      checks++;
      if ({a0, a1, a2, a3} !== 4'b1110)
         $display("FAIL ninc_acks: got %b want 1110", {a0, a1, a2, a3});
      else passes++;
      checks++;
      if (stb_cnt - stb0 !== 1) $display("FAIL ninc_stb: got %0d want 1", stb_cnt - stb0);
      else passes++;
      fab_read(8'h20, d);
      checks++;
      if (d !== 8'h11) $display("FAIL ninc_r20: got %h want 11", d);
      else passes++;
      fab_read(8'h21, d);
      checks++;
      if (d !== 8'h00) $display("FAIL ninc_r21: got %h want 00", d);
      else passes++;
   endtask

   task automatic test_rep_start();
      logic a0, a1, a2, a3, a4, a5, na;
      logic [7:0] d;
      do_start();
      send_byte(8'h42, a0);
      send_byte(8'h0A, a1);
      send_byte(8'h5C, a2);
      do_stop();
      do_start();
      send_byte(8'h42, a3);
      send_byte(8'h0A, a4);
      m_sda = 1'b1;
      tick(5);
      sio_c = 1'b1;
      tick(5);
      m_sda = 1'b0;
      tick(3);
      checks++;
      if (sio_d_oe !== 1'b0) $display("FAIL rs_oe_start: got %b want 0", sio_d_oe);
      else passes++;
      tick(2);
      sio_c = 1'b0;
      tick(5);
      send_byte(8'h43, a5);
      read_byte(d, na);
      do_stop();
      checks++;
      if ({a0, a1, a2, a3, a4, a5} !== 6'h3F)
         $display("FAIL rs_acks: got %b want 111111", {a0, a1, a2, a3, a4, a5});
      else passes++;
      checks++;
      if (d !== 8'h5C) $display("FAIL rs_data: got %h want 5c", d);
      else passes++;
   endtask

   task automatic test_reset_mid();
      logic a0, a1, a2, a3, a4, s;
      logic [7:0] d;
      do_start();
      send_byte(8'h42, a0);
      send_byte(8'h12, a1);
      do_stop();
      do_start();
      send_byte(8'h43, a2);
      for (int i = 0; i < 3; i++) bit_cycle(1'b1, s);
      m_sda = 1'b1;
      tick(5);
      sio_c = 1'b1;
      tick(3);
      checks++;
      if (sio_d_oe !== 1'b1) $display("FAIL rm_oe_before: got %b want 1", sio_d_oe);
      else passes++;
      rst = 1'b0;
      #2;
      checks++;
      if (sio_d_oe !== 1'b0) $display("FAIL rm_oe_async: got %b want 0", sio_d_oe);
      else passes++;
      checks++;
      if ({busy_o, reg_wr_stb, reg_addr_o, reg_wdata_o} !== 18'h0)
         $display("FAIL rm_outs: got %h want 0", {busy_o, reg_wr_stb, reg_addr_o, reg_wdata_o});
      else passes++;
      tick(3);
      rst = 1'b1;
      tick(5);
      fab_read(8'h12, d);
      checks++;
      if (d !== 8'h00) $display("FAIL rm_reg_clr: got %h want 00", d);
      else passes++;
      fab_read(8'h0A, d);
      checks++;
      if (d !== 8'h00) $display("FAIL rm_reg_clr2: got %h want 00", d);
      else passes++;
      do_start();
      send_byte(8'h42, a3);
      send_byte(8'h33, a4);
      send_byte(8'h77, s);
      do_stop();
      checks++;
      if ({a0, a1, a2, a3, a4, s} !== 6'h3F)
         $display("FAIL rm_acks: got %b want 111111", {a0, a1, a2, a3, a4, s});
      else passes++;
      checks++;
      if ({reg_addr_o, reg_wdata_o} !== 16'h3377)
         $display("FAIL rm_after: got %h want 3377", {reg_addr_o, reg_wdata_o});
      else passes++;
      fab_read(8'h33, d);
      checks++;
      if (d !== 8'h77) $display("FAIL rm_fabric: got %h want 77", d);
      else passes++;
   endtask

   initial begin
      tick(3);
      rst = 1'b1;
      test_reset();
      test_write3();
      test_read2();
      test_bad_id();
      test_no_autoinc();
      test_rep_start();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
